// File: rtl/aes_job_scheduler_pkg.sv
// aes_ctrl_pkg: shared types and constants for the AES job scheduler.
//   state_t    : scheduler FSM states (IDLE/ISSUE/WAIT/RESP)
//   BLOCK_SIZE : AES block width in bits
//   MODE_ENC/MODE_DEC : encoding of the per-request mode bit
package aes_ctrl_pkg;

  localparam int BLOCK_SIZE = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/aes_job_scheduler_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
// The search starts at the requester after i_last_grant and wraps around.
//   i_req        : request vector
//   i_last_grant : index of the previously granted requester
//   i_en         : arbitration enable; no grant while low
//   o_gnt        : one-hot grant (all zero when disabled or no request)
//   o_idx        : binary index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    // Offset 1..NUM_REQ visits every requester once, ending on last_grant itself.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(i_last_grant) + k) % NUM_REQ);
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        o_idx   = w_cand;
      end
    end
    if (w_found) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: shares one AES Cipher/InvCipher core between NUM_REQ
// requesters. Round-robin grant in IDLE, one-cycle launch pulse in ISSUE,
// supervised wait with timeout in WAIT, tagged response in RESP.
//   clk, reset_n            : clock, asynchronous active-low reset
//   req_valid/req_ready     : per-requester handshake (ready is one-hot or zero)
//   req_mode, req_data      : per-requester mode bit and 128-bit block
//   core_start              : one-cycle launch pulse to the core
//   core_mode, core_in      : registered operation mode and block
//   core_done, core_out     : core completion pulse and result
//   rsp_valid/rsp_ready     : response handshake
//   rsp_data, rsp_id        : result block and served requester index
//   rsp_error               : high when the job was aborted by timeout
//   busy                    : high whenever the FSM is not in IDLE
module aes_job_scheduler
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_mode,
  input  logic [NUM_REQ*BLOCK_SIZE-1:0] req_data,
  output logic                          core_start,
  output logic                          core_mode,
  output logic [BLOCK_SIZE-1:0]         core_in,
  input  logic                          core_done,
  input  logic [BLOCK_SIZE-1:0]         core_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [BLOCK_SIZE-1:0]         rsp_data,
  output logic [IDX_W-1:0]              rsp_id,
  output logic                          rsp_error,
  output logic                          busy
);

  // Counter only ever needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [IDX_W-1:0]      r_last_grant;
  logic [BLOCK_SIZE-1:0] r_core_in;
  logic                  r_core_mode;
  logic [BLOCK_SIZE-1:0] r_rsp_data;
  logic [IDX_W-1:0]      r_rsp_id;
  logic                  r_rsp_error;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_grant_en;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_done;
  logic                  w_timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .i_en         (w_grant_en),
    .o_gnt        (w_gnt),
    .o_idx        (w_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    core_start  = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        busy       = 1'b0;
        w_grant_en = 1'b1;
        if (|req_valid) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        core_start  = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (core_done) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_core_in    <= '0;
      r_core_mode  <= MODE_ENC;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
      r_rsp_error  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (|w_gnt) begin
        r_core_in    <= req_data[w_idx*BLOCK_SIZE +: BLOCK_SIZE];
        r_core_mode  <= req_mode[w_idx];
        r_rsp_id     <= w_idx;
        r_last_grant <= w_idx;
      end
      if (r_state == ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_rsp_data  <= core_out;
        r_rsp_error <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data  <= '0;
        r_rsp_error <= 1'b1;
      end
    end
  end

  assign req_ready = w_gnt;
  assign core_in   = r_core_in;
  assign core_mode = r_core_mode;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_aes_job_scheduler.sv
module tb_aes_job_scheduler;
  import aes_ctrl_pkg::*;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] D1   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] SPUR = 128'hdeadbeef0badf00dcafebabe12345678;

  typedef struct packed {
    logic         id;
    logic [127:0] data;
    logic         err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  // DUT A: TIMEOUT=64
  logic [1:0]   a_req_valid, a_req_ready, a_req_mode;
  logic [255:0] a_req_data;
  logic         a_core_start, a_core_mode, a_core_done, a_rsp_valid, a_rsp_ready, a_rsp_error, a_busy;
  logic [127:0] a_core_in, a_core_out, a_rsp_data;
  logic [0:0]   a_rsp_id;
  logic         a_spur;
  // DUT B: TIMEOUT=8
  logic [1:0]   b_req_valid, b_req_ready, b_req_mode;
  logic [255:0] b_req_data;
  logic         b_core_start, b_core_mode, b_core_done, b_rsp_valid, b_rsp_ready, b_rsp_error, b_busy;
  logic [127:0] b_core_in, b_core_out, b_rsp_data;
  logic [0:0]   b_rsp_id;
  logic         b_done_en;

  int lat_a;
  int lat_b;

  // Modeled core: FIPS-197 vector pair for the key 000102..0f, simple
  // distinct transforms otherwise.
  function automatic logic [127:0] core_fn(input logic mode, input logic [127:0] din);
    if (mode == MODE_ENC) return (din == PT) ? CT : (din ^ {4{32'h5a5aa5a5}});
    else                  return (din == CT) ? PT : {din[63:0], din[127:64]};
  endfunction

  logic m_a_busy, m_a_done, m_a_mode;
  logic [127:0] m_a_out, m_a_in;
  int m_a_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a_busy <= 1'b0; m_a_done <= 1'b0; m_a_mode <= 1'b0;
      m_a_out <= '0; m_a_in <= '0; m_a_cnt <= 0;
    end else begin
      m_a_done <= 1'b0;
      if (m_a_busy) begin
        if (m_a_cnt == 1) begin
          m_a_done <= 1'b1; m_a_out <= core_fn(m_a_mode, m_a_in); m_a_busy <= 1'b0;
        end else m_a_cnt <= m_a_cnt - 1;
      end
      if (a_core_start) begin
        m_a_busy <= 1'b1; m_a_cnt <= lat_a; m_a_mode <= a_core_mode; m_a_in <= a_core_in;
      end
    end
  end
  assign a_core_done = m_a_done | a_spur;
  assign a_core_out  = a_spur ? SPUR : m_a_out;

  logic m_b_busy, m_b_done, m_b_mode;
  logic [127:0] m_b_out, m_b_in;
  int m_b_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_b_busy <= 1'b0; m_b_done <= 1'b0; m_b_mode <= 1'b0;
      m_b_out <= '0; m_b_in <= '0; m_b_cnt <= 0;
    end else begin
      m_b_done <= 1'b0;
      if (m_b_busy) begin
        if (m_b_cnt == 1) begin
          m_b_busy <= 1'b0;
          if (b_done_en) begin
            m_b_done <= 1'b1; m_b_out <= core_fn(m_b_mode, m_b_in);
          end
        end else m_b_cnt <= m_b_cnt - 1;
      end
      if (b_core_start) begin
        m_b_busy <= 1'b1; m_b_cnt <= lat_b; m_b_mode <= b_core_mode; m_b_in <= b_core_in;
      end
    end
  end
  assign b_core_done = m_b_done;
  assign b_core_out  = m_b_out;

  aes_job_scheduler #(.NUM_REQ(2), .TIMEOUT(64)) u_a (
    .clk(clk), .reset_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_mode(a_req_mode), .req_data(a_req_data),
    .core_start(a_core_start), .core_mode(a_core_mode), .core_in(a_core_in),
    .core_done(a_core_done), .core_out(a_core_out),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .rsp_id(a_rsp_id), .rsp_error(a_rsp_error), .busy(a_busy)
  );

  aes_job_scheduler #(.NUM_REQ(2), .TIMEOUT(8)) u_b (
    .clk(clk), .reset_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_mode(b_req_mode), .req_data(b_req_data),
    .core_start(b_core_start), .core_mode(b_core_mode), .core_in(b_core_in),
    .core_done(b_core_done), .core_out(b_core_out),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_id(b_rsp_id), .rsp_error(b_rsp_error), .busy(b_busy)
  );

  // Cycle count from the current point until rsp_valid is seen at a negedge.
  task automatic wait_rsp_a(input int limit, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (a_rsp_valid !== 1'b1 && cyc < limit);
  endtask

  task automatic wait_rsp_b(input int limit, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (b_rsp_valid !== 1'b1 && cyc < limit);
  endtask

  task automatic accept_a();
    a_rsp_ready = 1'b1;
    @(posedge clk); #1 a_rsp_ready = 1'b0;
  endtask

  task automatic accept_b();
    b_rsp_ready = 1'b1;
    @(posedge clk); #1 b_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({a_req_ready, a_core_start, a_core_mode, a_core_in, a_rsp_valid, a_rsp_data, a_rsp_id, a_rsp_error, a_busy} !== 264'd0) begin
      failures++;
      $display("FAIL reset_a: outputs=%h required all zero",
               {a_req_ready, a_core_start, a_core_mode, a_core_in, a_rsp_valid, a_rsp_data, a_rsp_id, a_rsp_error, a_busy});
    end
    checks++;
    if ({b_req_ready, b_core_start, b_core_mode, b_core_in, b_rsp_valid, b_rsp_data, b_rsp_id, b_rsp_error, b_busy} !== 264'd0) begin
      failures++;
      $display("FAIL reset_b: outputs=%h required all zero",
               {b_req_ready, b_core_start, b_core_mode, b_core_in, b_rsp_valid, b_rsp_data, b_rsp_id, b_rsp_error, b_busy});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    int cyc;
    exp_t e;
    @(negedge clk);
    a_req_data[127:0] = PT; a_req_mode[0] = MODE_ENC;
    a_req_data[255:128] = CT; a_req_mode[1] = MODE_DEC;
    a_req_valid = 2'b11; a_rsp_ready = 1'b1;
    sb_a.push_back('{1'b0, CT, 1'b0});
    sb_a.push_back('{1'b1, PT, 1'b0});
    sb_a.push_back('{1'b0, CT, 1'b0});
    sb_a.push_back('{1'b1, PT, 1'b0});
    #1;
    checks++;
    if (a_req_ready !== 2'b01) begin
      failures++; $display("FAIL fair_first_grant: req_ready=%b required 01", a_req_ready);
    end
    for (int j = 0; j < 4; j++) begin
      wait_rsp_a(60, cyc);
      if (j > 0) begin
        checks++;
        if (cyc != 14) begin
          failures++; $display("FAIL fair_period%0d: period=%0d required 14", j, cyc);
        end
      end
      if (j == 3) a_req_valid = 2'b00;
      checks++;
      if (sb_a.size() == 0) begin
        failures++; $display("FAIL fair_rsp%0d: scoreboard empty", j);
      end else begin
        e = sb_a.pop_front();
        if ({a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_error} !== {1'b1, e.id, e.data, e.err}) begin
          failures++;
          $display("FAIL fair_rsp%0d: valid=%b id=%0d data=%h err=%b required id=%0d data=%h err=%b",
                   j, a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_error, e.id, e.data, e.err);
        end
      end
    end
    @(posedge clk); #1 a_rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin
      failures++; $display("FAIL fair_idle: busy=%b required 0", a_busy);
    end
  endtask

  task automatic test_single();
    int cyc;
    exp_t e;
    @(negedge clk);
    a_req_data[127:0] = PT; a_req_mode[0] = MODE_ENC; a_req_valid = 2'b01;
    sb_a.push_back('{1'b0, CT, 1'b0});
    #1;
    checks++;
    if (a_req_ready !== 2'b01) begin
      failures++; $display("FAIL single_grant: req_ready=%b required 01", a_req_ready);
    end
    @(posedge clk); #1 a_req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({a_core_start, a_core_mode, a_core_in, a_busy, a_req_ready} !== {1'b1, MODE_ENC, PT, 1'b1, 2'b00}) begin
      failures++;
      $display("FAIL single_issue: start=%b mode=%b in=%h busy=%b ready=%b required 1 0 %h 1 00",
               a_core_start, a_core_mode, a_core_in, a_busy, a_req_ready, PT);
    end
    @(negedge clk);
    checks++;
    if (a_core_start !== 1'b0) begin
      failures++; $display("FAIL single_start_pulse: core_start=%b required 0 in WAIT", a_core_start);
    end
    wait_rsp_a(40, cyc);
    checks++;
    if (cyc + 2 != 13) begin
      failures++; $display("FAIL single_latency: rsp_valid at cycle %0d required 13", cyc + 2);
    end
    checks++;
    if (sb_a.size() == 0) begin
      failures++; $display("FAIL single_rsp: scoreboard empty");
    end else begin
      e = sb_a.pop_front();
      if ({a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_error} !== {1'b1, e.id, e.data, e.err}) begin
        failures++;
        $display("FAIL single_rsp: valid=%b id=%0d data=%h err=%b required id=%0d data=%h err=%b",
                 a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_error, e.id, e.data, e.err);
      end
    end
    accept_a();
  endtask

  task automatic test_backpressure();
    int cyc;
    exp_t e;
    logic [127:0] held;
    @(negedge clk);
    a_req_data[255:128] = D1; a_req_mode[1] = MODE_ENC; a_req_valid = 2'b10;
    sb_a.push_back('{1'b1, D1 ^ {4{32'h5a5aa5a5}}, 1'b0});
    held = D1 ^ {4{32'h5a5aa5a5}};
    @(posedge clk); #1;
    a_req_data[127:0] = PT; a_req_mode[0] = MODE_ENC; a_req_valid = 2'b01;
    sb_a.push_back('{1'b0, CT, 1'b0});
    wait_rsp_a(40, cyc);
    checks++;
    if (sb_a.size() == 0) begin
      failures++; $display("FAIL bp_rsp1: scoreboard empty");
    end else begin
      e = sb_a.pop_front();
      if ({a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_error} !== {1'b1, e.id, e.data, e.err}) begin
        failures++;
        $display("FAIL bp_rsp1: valid=%b id=%0d data=%h err=%b required id=%0d data=%h err=%b",
                 a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_error, e.id, e.data, e.err);
      end
    end
    for (int i = 0; i < 5; i++) begin
      a_spur = (i == 1);
      @(negedge clk);
      checks++;
      if ({a_rsp_valid, a_rsp_data, a_rsp_id, a_req_ready} !== {1'b1, held, 1'b1, 2'b00}) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b data=%h id=%0d ready=%b required 1 %h 1 00",
                 i, a_rsp_valid, a_rsp_data, a_rsp_id, a_req_ready, held);
      end
    end
    a_spur = 1'b0;
    accept_a();
    @(negedge clk);
    checks++;
    if (a_req_ready !== 2'b01) begin
      failures++; $display("FAIL bp_next_grant: req_ready=%b required 01 one cycle after accept", a_req_ready);
    end
    @(posedge clk); #1 a_req_valid = 2'b00;
    wait_rsp_a(40, cyc);
    checks++;
    if (sb_a.size() == 0) begin
      failures++; $display("FAIL bp_rsp2: scoreboard empty");
    end else begin
      e = sb_a.pop_front();
      if ({a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_error} !== {1'b1, e.id, e.data, e.err}) begin
        failures++;
        $display("FAIL bp_rsp2: valid=%b id=%0d data=%h err=%b required id=%0d data=%h err=%b",
                 a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_error, e.id, e.data, e.err);
      end
    end
    accept_a();
  endtask

  task automatic test_idle_spurious();
    logic bad;
    bad = 1'b0;
    @(negedge clk); a_spur = 1'b1;
    @(negedge clk); a_spur = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a_busy !== 1'b0 || a_rsp_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL idle_spurious_done: busy/rsp_valid seen high=%b required 0", bad);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    exp_t e;
    b_done_en = 1'b0; lat_b = 5;
    @(negedge clk);
    b_req_data[127:0] = PT; b_req_mode[0] = MODE_ENC; b_req_valid = 2'b01;
    sb_b.push_back('{1'b0, 128'd0, 1'b1});
    @(posedge clk); #1 b_req_valid = 2'b00;
    wait_rsp_b(30, cyc);
    checks++;
    if (cyc != 10) begin
      failures++; $display("FAIL timeout_latency: rsp_valid at cycle %0d required 10", cyc);
    end
    checks++;
    if (sb_b.size() == 0) begin
      failures++; $display("FAIL timeout_rsp: scoreboard empty");
    end else begin
      e = sb_b.pop_front();
      if ({b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_error} !== {1'b1, e.id, e.data, e.err}) begin
        failures++;
        $display("FAIL timeout_rsp: valid=%b id=%0d data=%h err=%b required id=%0d data=%h err=%b",
                 b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_error, e.id, e.data, e.err);
      end
    end
    accept_b();
    b_done_en = 1'b1; lat_b = 3;
    @(negedge clk);
    b_req_data[255:128] = CT; b_req_mode[1] = MODE_DEC; b_req_valid = 2'b10;
    sb_b.push_back('{1'b1, PT, 1'b0});
    @(posedge clk); #1 b_req_valid = 2'b00;
    wait_rsp_b(30, cyc);
    checks++;
    if (cyc != 6) begin
      failures++; $display("FAIL recover_latency: rsp_valid at cycle %0d required 6", cyc);
    end
    checks++;
    if (sb_b.size() == 0) begin
      failures++; $display("FAIL recover_rsp: scoreboard empty");
    end else begin
      e = sb_b.pop_front();
      if ({b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_error} !== {1'b1, e.id, e.data, e.err}) begin
        failures++;
        $display("FAIL recover_rsp: valid=%b id=%0d data=%h err=%b required id=%0d data=%h err=%b",
                 b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_error, e.id, e.data, e.err);
      end
    end
    accept_b();
  endtask

  task automatic test_boundary();
    int cyc;
    exp_t e;
    // L=7: done coincides with the last count, done wins.
    lat_b = 7;
    @(negedge clk);
    b_req_data[127:0] = PT; b_req_mode[0] = MODE_ENC; b_req_valid = 2'b01;
    sb_b.push_back('{1'b0, CT, 1'b0});
    @(posedge clk); #1 b_req_valid = 2'b00;
    wait_rsp_b(30, cyc);
    checks++;
    if (cyc != 10) begin
      failures++; $display("FAIL boundary_latency: rsp_valid at cycle %0d required 10", cyc);
    end
    checks++;
    if (sb_b.size() == 0) begin
      failures++; $display("FAIL boundary_rsp: scoreboard empty");
    end else begin
      e = sb_b.pop_front();
      if ({b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_error} !== {1'b1, e.id, e.data, e.err}) begin
        failures++;
        $display("FAIL boundary_rsp: valid=%b id=%0d data=%h err=%b required id=%0d data=%h err=%b",
                 b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_error, e.id, e.data, e.err);
      end
    end
    accept_b();
    // L=8: timeout one cycle early; the late done lands in RESP and is ignored.
    lat_b = 8;
    @(negedge clk);
    b_req_valid = 2'b01;
    sb_b.push_back('{1'b0, 128'd0, 1'b1});
    @(posedge clk); #1 b_req_valid = 2'b00;
    wait_rsp_b(30, cyc);
    checks++;
    if (sb_b.size() == 0) begin
      failures++; $display("FAIL late_done_rsp: scoreboard empty");
    end else begin
      e = sb_b.pop_front();
      if ({b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_error} !== {1'b1, e.id, e.data, e.err}) begin
        failures++;
        $display("FAIL late_done_rsp: cycle=%0d valid=%b id=%0d data=%h err=%b required id=%0d data=%h err=%b",
                 cyc, b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_error, e.id, e.data, e.err);
      end
    end
    @(negedge clk);
    checks++;
    if ({b_rsp_valid, b_rsp_data, b_rsp_error} !== {1'b1, 128'd0, 1'b1}) begin
      failures++;
      $display("FAIL resp_spurious_done: valid=%b data=%h err=%b required 1 0 1", b_rsp_valid, b_rsp_data, b_rsp_error);
    end
    accept_b();
  endtask

  task automatic test_reset_mid_wait();
    int cyc;
    exp_t e;
    logic bad;
    lat_a = 10;
    @(negedge clk);
    a_req_data[255:128] = D1; a_req_mode[1] = MODE_ENC; a_req_valid = 2'b10;
    @(posedge clk); #1 a_req_valid = 2'b00;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_req_ready, a_core_start, a_core_mode, a_core_in, a_rsp_valid, a_rsp_data, a_rsp_id, a_rsp_error, a_busy} !== 264'd0) begin
      failures++;
      $display("FAIL midreset_outputs: outputs=%h required all zero",
               {a_req_ready, a_core_start, a_core_mode, a_core_in, a_rsp_valid, a_rsp_data, a_rsp_id, a_rsp_error, a_busy});
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_rsp_valid !== 1'b0 || a_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL midreset_discard: rsp_valid/busy seen high=%b required 0", bad);
    end
    a_req_data[127:0] = PT; a_req_mode[0] = MODE_ENC;
    a_req_data[255:128] = CT; a_req_mode[1] = MODE_DEC;
    a_req_valid = 2'b11;
    sb_a.push_back('{1'b0, CT, 1'b0});
    #1;
    checks++;
    if (a_req_ready !== 2'b01) begin
      failures++; $display("FAIL midreset_priority: req_ready=%b required 01", a_req_ready);
    end
    @(posedge clk); #1 a_req_valid = 2'b00;
    wait_rsp_a(40, cyc);
    checks++;
    if (sb_a.size() == 0) begin
      failures++; $display("FAIL midreset_rsp: scoreboard empty");
    end else begin
      e = sb_a.pop_front();
      if ({a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_error} !== {1'b1, e.id, e.data, e.err}) begin
        failures++;
        $display("FAIL midreset_rsp: valid=%b id=%0d data=%h err=%b required id=%0d data=%h err=%b",
                 a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_error, e.id, e.data, e.err);
      end
    end
    accept_a();
    checks++;
    if (sb_a.size() + sb_b.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: %0d entries left required 0", sb_a.size() + sb_b.size());
    end
  endtask

  initial begin
    a_req_valid = '0; a_req_mode = '0; a_req_data = '0; a_rsp_ready = 1'b0; a_spur = 1'b0;
    b_req_valid = '0; b_req_mode = '0; b_req_data = '0; b_rsp_ready = 1'b0; b_done_en = 1'b1;
    lat_a = 10; lat_b = 5;
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_idle_spurious();
    test_timeout();
    test_boundary();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_job_scheduler.md
# aes_job_scheduler

Shares one AES core pair (Cipher + InvCipher behind a common start/done port) between `NUM_REQ` requesters. It round-robin arbitrates block requests, launches the selected operation, and supervises completion with a timeout. It returns the result over a valid/ready response channel tagged with the requester index. It sits between the system request fabric and the AES datapath; round keys come from the existing key expansion and are not handled here.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters (≥2).
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before the operation is aborted (≥2).
- `IDX_W`, derived as clog2(`NUM_REQ`): width of the requester index.

Ports:
- `clk` in, 1 bit: single clock.
- `reset_n` in, 1 bit: asynchronous, active-low reset.
- `req_valid` in, `NUM_REQ` bits: per-requester request valid.
- `req_ready` out, `NUM_REQ` bits: per-requester accept (one-hot or zero).
- `req_mode` in, `NUM_REQ` bits: per-requester mode, 0 = encrypt, 1 = decrypt.
- `req_data` in, `NUM_REQ`*128 bits: per-requester block; requester i occupies bits [128i+127:128i].
- `core_start` out, 1 bit: one-cycle launch pulse.
- `core_mode` out, 1 bit: registered mode.
- `core_in` out, 128 bits: registered block.
- `core_done` in, 1 bit: completion pulse from the core.
- `core_out` in, 128 bits: core result, valid while `core_done` is high.
- `rsp_valid` out, 1 bit: response valid.
- `rsp_ready` in, 1 bit: response accept.
- `rsp_data` out, 128 bits: result block.
- `rsp_id` out, `IDX_W` bits: index of the requester served.
- `rsp_error` out, 1 bit: high means timeout abort.
- `busy` out, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is high, the round-robin winner g is searched starting at `last_grant`+1 (wrapping).
  - `req_ready[g]`=1 combinationally in the same cycle. The handshake registers `req_data`/`req_mode` slice g, sets `rsp_id`=g and `last_grant`=g, then moves to ISSUE.
- ISSUE:
  - `core_start`=1 for exactly this cycle.
  - Clear the timeout counter, then move to WAIT.
- WAIT:
  - The counter increments each cycle.
  - If `core_done`=1, register `core_out` into `rsp_data`, set `rsp_error`=0 and move to RESP.
  - If the counter reaches `TIMEOUT`-1 without `core_done`, set `rsp_data`=0, set `rsp_error`=1 and move to RESP.
  - If `core_done` and timeout occur in the same cycle, done wins.
- RESP:
  - `rsp_valid`=1, with `rsp_data`/`rsp_id`/`rsp_error` held stable.
  - On `rsp_ready` move to IDLE.
- `req_ready` is all-zero outside IDLE. `core_done` is ignored outside WAIT.
- `core_in`/`core_mode` stay stable from ISSUE until the next grant.
- Reset values:
  - FSM in IDLE.
  - `last_grant` = `NUM_REQ`-1, so requester 0 has first priority.
  - All outputs 0: `core_in`, `rsp_data`, `rsp_id`, `rsp_error`, `core_start`, `rsp_valid`, `busy`, `req_ready`.
- Reset mid-operation: state returns to IDLE immediately and any in-flight result is discarded. The core shares `reset_n`.

## Timing
- Grant happens in cycle 0 (the handshake cycle), `core_start` in cycle 1, and WAIT begins in cycle 2.
- If `core_done` arrives in cycle 2+L, `rsp_valid` rises in cycle 3+L.
- Back-to-back throughput: the next grant can occur in the cycle after the `rsp_valid`&`rsp_ready` handshake. The minimum period is 4+L cycles.
- A timeout raises `rsp_valid` at cycle 2+`TIMEOUT`.
- No combinational path from `req_*` to `core_*` or `rsp_*`. The only combinational path is `req_valid` to `req_ready`.

## Structure
- Package `aes_ctrl_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - `BLOCK_SIZE`=128;
  - the mode constants `MODE_ENC`=0 and `MODE_DEC`=1.
- Sub-module `rr_arbiter` (parameter `NUM_REQ`):
  - inputs: request vector, `last_grant`, enable;
  - outputs: one-hot grant and the binary index;
  - purely combinational.
- The top level holds the FSM, data registers and timeout counter.

## Test plan
- Single request: requester 0 sends encrypt of 00112233445566778899aabbccddeeff (key 000102…0f, modeled core, L=10). Required: `rsp_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_id`=0, `rsp_error`=0, `rsp_valid` at cycle 13.
- Fairness: both requesters hold `req_valid` continuously for 4 jobs. Required: grants alternate 0,1,0,1. Requester 1 sends decrypt of 69c4…c55a and receives 0011…eeff.
- Response backpressure: `rsp_ready` is held low for 5 cycles. Required: `rsp_valid`/`rsp_data` stay stable, `req_ready` stays 0, and the next grant comes 1 cycle after acceptance.
- Timeout: `core_done` is never asserted with `TIMEOUT`=8. Required: `rsp_error`=1, `rsp_data`=0, `rsp_valid` at cycle 10, and the FSM recovers to serve the next request normally.
- Boundary: `core_done` arrives in the same cycle the counter hits `TIMEOUT`-1. Required: `rsp_error`=0 with the core data. A spurious `core_done` in IDLE or RESP is ignored.
- Reset mid-WAIT: `reset_n` is pulsed low. Required: all outputs read 0 asynchronously, no `rsp_valid` appears, and after release requester 0 has first priority.
